calc_alu_seq: RTL and testbench
===============================

# calc_alu_seq

Parametrised, multi-cycle arithmetic unit for the calculator datapath, successor to the single-cycle 4-bit/16-bit ALU. It takes an operand from the keypad path (A) and the accumulator value (B), and executes the opcode from the op register. Add, subtract and pass-through complete in one cycle; multiply uses iterative shift-add and divide uses restoring long division. Operands are captured through a valid/ready handshake, and the result is held until the consumer accepts it. Status flags report overflow/borrow and divide-by-zero.

## Interface
- A_W, 4: width of operand A.
- B_W, 16: width of operand B, quotient and result; must be ≥ A_W.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  operands/opcode present.
- in_ready  output  1  high only in IDLE; acceptance = in_valid & in_ready at a rising edge.
- a  input  A_W  operand A, unsigned.
- b  input  B_W  operand B (accumulator), unsigned.
- sel  input  3  opcode: 100 add, 101 sub, 110 mul, 111 div; any other value is NOP.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- result  output  B_W  sum / difference / product / quotient / 0.
- remainder  output  B_W  div remainder; 0 for all other ops.
- ovf  output  1  add carry-out, sub borrow, or mul truncation.
- dz  output  1  divide by zero.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset → IDLE.
- IDLE, on accept: register a, b and sel.
  - add/sub/NOP: compute the result, then → DONE.
  - mul: → MUL.
  - div, a≠0: → DIV.
  - div, a==0: → DONE.
- Add: result = zext(a)+b mod 2^B_W; ovf = carry out of bit B_W-1.
- Sub: result = zext(a)−b mod 2^B_W (two's-complement wrap); ovf = 1 iff b > zext(a).
- Mul: A_W iterations, one per cycle, LSB of a first. Each iteration adds (b << i) into a (B_W+A_W)-bit accumulator when a[i]=1. result = low B_W bits; ovf = 1 iff any high A_W bits are nonzero.
- Div: quotient = b / zext(a), via B_W restoring iterations, MSB first, one per cycle. result = quotient; remainder = b mod a; ovf = 0.
- Div by zero: result = all ones, remainder = b, dz = 1, ovf = 0.
- NOP: result = 0, remainder = 0, flags 0.
- DONE: out_valid = 1; result, remainder and flags are stable. On out_ready → IDLE.
- No new operation is accepted while the unit is busy or holding a result. Inputs a, b and sel are ignored outside an accepting IDLE cycle, so changes mid-operation have no effect.

## Timing
- Reset values: out_valid 0, result 0, remainder 0, ovf 0, dz 0, state IDLE, in_ready 1, internal counters/accumulators 0.
- Reset asserted mid-MUL/DIV/DONE: the operation is aborted immediately; no out_valid pulse after reset is released.
- Latency, from the accepting edge to the edge that raises out_valid:
  - add/sub/NOP/div-by-zero: 1.
  - mul: A_W+1.
  - div: B_W+1.
- Handshake and throughput:
  - in_ready returns to 1 the cycle after output acceptance.
  - Maximum throughput is one operation per 2 cycles for single-cycle ops.
  - out_ready held high before out_valid rises causes no extra delay; acceptance happens on the first out_valid cycle.
- out_valid never deasserts without acceptance. result, remainder and flags change only on the edge entering DONE or on reset.

## Test plan
- Add, A_W=4/B_W=16: a=3, b=10 → result=13, ovf=0, out_valid 1 cycle after accept. Add a=15, b=0xFFFF → result=0x000E, ovf=1.
- Sub: a=3, b=10 → result=0xFFF9, ovf=1. Then a=10, b=3 → result=7, ovf=0.
- Mul: a=15, b=0x2000 → result=0xE000, ovf=1, out_valid exactly 5 cycles after accept. a=5, b=7 → 35, ovf=0.
- Div: a=7, b=100 → result=14, remainder=2, out_valid 17 cycles after accept. Div a=0, b=100 → result=0xFFFF, remainder=100, dz=1, latency 1.
- Backpressure and NOP: hold out_ready=0 for 10 cycles after out_valid. Outputs stay stable, in_ready stays 0, and a second in_valid is ignored. Release → accept, then in_ready=1 next cycle. sel=011 → result 0, flags 0.
- Reset in DIV: assert reset 5 cycles into a div. All outputs go to reset values asynchronously. After release, no out_valid appears, and a fresh add a=1, b=1 → 2.

Source files
------------

// File: rtl/calc_alu_seq_if.sv
// Operand/result handshake bundle for calc_alu_seq.
// master drives operands and accepts results; slave is the arithmetic unit.
interface calc_alu_seq_if #(
   parameter int A_W = 4,
   parameter int B_W = 16
);
   logic           in_valid;
   logic           in_ready;
   logic [A_W-1:0] a;
   logic [B_W-1:0] b;
   logic [2:0]     sel;
   logic           out_valid;
   logic           out_ready;
   logic [B_W-1:0] result;
   logic [B_W-1:0] remainder;
   logic           ovf;
   logic           dz;

   modport master (
      output in_valid, a, b, sel, out_ready,
      input  in_ready, out_valid, result, remainder, ovf, dz
   );

   modport slave (
      input  in_valid, a, b, sel, out_ready,
      output in_ready, out_valid, result, remainder, ovf, dz
   );
endinterface

// File: rtl/calc_alu_seq.sv
// Multi-cycle calculator ALU: single-cycle add/sub/NOP, shift-add multiply,
// restoring divide; result is held in DONE until the consumer accepts it.
module calc_alu_seq #(
   parameter int A_W = 4,
   parameter int B_W = 16
) (
   input logic          clk,
   input logic          reset,
   calc_alu_seq_if.slave bus
);
   localparam int CW = $clog2(B_W + 1);
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_DIV = 3'b111;
   localparam logic [CW-1:0] MUL_LAST = CW'(A_W - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(B_W - 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t state, state_nx;

   logic              in_ready, out_valid, accept;
   logic [CW-1:0]     cnt;
   logic [A_W-1:0]    ma;
   logic [B_W+A_W-1:0] mb, acc, acc_nx;
   logic [A_W-1:0]    dv, rm, rm_nx;
   logic [B_W-1:0]    dq, dq_nx;
   logic [A_W:0]      trial, dv_ext;
   logic              ge;
   logic [B_W-1:0]    a_ext;
   logic [B_W-1:0]    q_result, q_rem;
   logic              q_ovf, q_dz;
   logic [B_W-1:0]    result_r, rem_r;
   logic              ovf_r, dz_r;

   assign a_ext  = B_W'(bus.a);
   assign accept = bus.in_valid & in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               if (bus.sel == OP_MUL)                      state_nx = MUL;
               else if (bus.sel == OP_DIV && bus.a != '0)  state_nx = DIV;
               else                                        state_nx = DONE;
            end
         end
         MUL:  if (cnt == MUL_LAST) state_nx = DONE;
         DIV:  if (cnt == DIV_LAST) state_nx = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_nx = IDLE;
         end
      endcase
   end

   // Ops that finish straight from IDLE, evaluated on the live operands.
   always_comb begin
      q_result = '0;
      q_rem    = '0;
      q_ovf    = 1'b0;
      q_dz     = 1'b0;
      unique case (bus.sel)
         OP_ADD: {q_ovf, q_result} = {1'b0, a_ext} + {1'b0, bus.b};
         OP_SUB: begin
            q_result = a_ext - bus.b;
            q_ovf    = bus.b > a_ext;
         end
         OP_DIV: begin
            q_result = '1;
            q_rem    = bus.b;
            q_dz     = 1'b1;
         end
         default: ;
      endcase
   end

   assign acc_nx = acc + (ma[0] ? mb : '0);

   // Partial remainder stays below the divisor, so A_W bits hold it.
   assign trial  = {rm, dq[B_W-1]};
   assign dv_ext = (A_W+1)'(dv);
   assign ge     = trial >= dv_ext;
   assign rm_nx  = ge ? A_W'(trial - dv_ext) : A_W'(trial);
   assign dq_nx  = {dq[B_W-2:0], ge};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         ma       <= '0;
         mb       <= '0;
         acc      <= '0;
         dv       <= '0;
         rm       <= '0;
         dq       <= '0;
         result_r <= '0;
         rem_r    <= '0;
         ovf_r    <= 1'b0;
         dz_r     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (accept) begin
               cnt <= '0;
               ma  <= bus.a;
               mb  <= (B_W+A_W)'(bus.b);
               acc <= '0;
               dv  <= bus.a;
               rm  <= '0;
               dq  <= bus.b;
               if (state_nx == DONE) begin
                  result_r <= q_result;
                  rem_r    <= q_rem;
                  ovf_r    <= q_ovf;
                  dz_r     <= q_dz;
               end
            end
            MUL: begin
               acc <= acc_nx;
               ma  <= ma >> 1;
               mb  <= mb << 1;
               cnt <= cnt + CW'(1);
               if (cnt == MUL_LAST) begin
                  result_r <= acc_nx[B_W-1:0];
                  rem_r    <= '0;
                  ovf_r    <= |acc_nx[B_W+A_W-1:B_W];
                  dz_r     <= 1'b0;
               end
            end
            DIV: begin
               rm  <= rm_nx;
               dq  <= dq_nx;
               cnt <= cnt + CW'(1);
               if (cnt == DIV_LAST) begin
                  result_r <= dq_nx;
                  rem_r    <= B_W'(rm_nx);
                  ovf_r    <= 1'b0;
                  dz_r     <= 1'b0;
               end
            end
            DONE: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.result    = result_r;
   assign bus.remainder = rem_r;
   assign bus.ovf       = ovf_r;
   assign bus.dz        = dz_r;
endmodule

// File: tb/tb_calc_alu_seq.sv
// Directed scoreboard bench for calc_alu_seq (A_W=4, B_W=16).
module tb_calc_alu_seq;
   localparam int A_W = 4;
   localparam int B_W = 16;

   typedef struct {
      logic [B_W-1:0] r;
      logic [B_W-1:0] rem;
      logic           ovf;
      logic           dz;
      int             lat;
   } exp_t;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   calc_alu_seq_if #(.A_W(A_W), .B_W(B_W)) bus ();

   calc_alu_seq #(.A_W(A_W), .B_W(B_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [A_W-1:0] av, input logic [B_W-1:0] bv,
                                  input logic [2:0] sv);
      exp_t e;
      longint unsigned ai, bi, m, t;
      ai = longint'(av);
      bi = longint'(bv);
      m  = (64'd1 << B_W) - 64'd1;
      e.r = '0; e.rem = '0; e.ovf = 1'b0; e.dz = 1'b0; e.lat = 1;
      case (sv)
         3'b100: begin
            t = ai + bi;
            e.r = B_W'(t & m);
            e.ovf = t > m;
         end
         3'b101: begin
            e.r = B_W'((ai - bi) & m);
            e.ovf = bi > ai;
         end
         3'b110: begin
            t = ai * bi;
            e.r = B_W'(t & m);
            e.ovf = t > m;
            e.lat = A_W + 1;
         end
         3'b111: begin
            if (ai == 0) begin
               e.r = B_W'(m);
               e.rem = bv;
               e.dz = 1'b1;
            end else begin
               e.r = B_W'(bi / ai);
               e.rem = B_W'(bi % ai);
               e.lat = B_W + 1;
            end
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic run_op(input string tag, input logic [A_W-1:0] av, input logic [B_W-1:0] bv,
                         input logic [2:0] sv, input bit hold, input bit pre_rdy);
      exp_t e;
      int   lat;
      sb.push_back(model(av, bv, sv));
      @(negedge clk);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.a = av; bus.b = bv; bus.sel = sv; bus.in_valid = 1'b1;
      if (pre_rdy) bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      e = sb.pop_front();
      check({tag, "_lat"}, 32'(lat), 32'(e.lat));
      check({tag, "_result"}, 32'(bus.result), 32'(e.r));
      check({tag, "_rem"}, 32'(bus.remainder), 32'(e.rem));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
      check({tag, "_dz"}, 32'(bus.dz), 32'(e.dz));
      if (hold) begin
         for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.a = ~av; bus.b = ~bv; bus.sel = 3'b100;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, "_hold_result"}, 32'(bus.result), 32'(e.r));
            check({tag, "_hold_ovf"}, 32'(bus.ovf), 32'(e.ovf));
         end
         bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
      check({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      bit seen;
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.sel = '0;
      #12;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_rem", 32'(bus.remainder), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      check("rst_dz", 32'(bus.dz), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op("add_3_10", 4'd3, 16'd10, 3'b100, 1'b0, 1'b0);
      run_op("add_wrap", 4'd15, 16'hFFFF, 3'b100, 1'b0, 1'b0);
      run_op("sub_borrow", 4'd3, 16'd10, 3'b101, 1'b0, 1'b0);
      run_op("sub_plain", 4'd10, 16'd3, 3'b101, 1'b0, 1'b1);
      run_op("mul_trunc", 4'd15, 16'h2000, 3'b110, 1'b0, 1'b0);
      run_op("mul_5_7", 4'd5, 16'd7, 3'b110, 1'b0, 1'b1);
      run_op("div_100_7", 4'd7, 16'd100, 3'b111, 1'b0, 1'b0);
      run_op("div_max", 4'd1, 16'hFFFF, 3'b111, 1'b0, 1'b0);
      run_op("mul_backpressure", 4'd9, 16'h1234, 3'b110, 1'b1, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1 || bus.in_ready !== 1'b1) seen = 1'b1;
      end
      check("ignored_in_valid", 32'(seen), 32'd0);
      run_op("nop_011", 4'd6, 16'd55, 3'b011, 1'b0, 1'b0);
      run_op("div_zero", 4'd0, 16'd100, 3'b111, 1'b0, 1'b0);

      @(negedge clk);
      bus.a = 4'd7; bus.b = 16'd1000; bus.sel = 3'b111; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("divrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("divrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("divrst_result", 32'(bus.result), 32'd0);
      check("divrst_rem", 32'(bus.remainder), 32'd0);
      check("divrst_dz", 32'(bus.dz), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      check("divrst_no_valid", 32'(seen), 32'd0);
      run_op("add_after_rst", 4'd1, 16'd1, 3'b100, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
